// File: rtl/smg_pkg.sv
// Shared types and constants for the seven-segment scan controller.
// Segment codes are active-high, bit0 = a ... bit6 = g, bit7 = dp.
package smg_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_CONV   = 2'd1,
        S_COMMIT = 2'd2
    } smg_state_t;

    localparam logic [15:0] SMG_MAX = 16'd9999;

    localparam logic [7:0] SEG_0     = 8'h3F;
    localparam logic [7:0] SEG_1     = 8'h06;
    localparam logic [7:0] SEG_2     = 8'h5B;
    localparam logic [7:0] SEG_3     = 8'h4F;
    localparam logic [7:0] SEG_4     = 8'h66;
    localparam logic [7:0] SEG_5     = 8'h6D;
    localparam logic [7:0] SEG_6     = 8'h7D;
    localparam logic [7:0] SEG_7     = 8'h07;
    localparam logic [7:0] SEG_8     = 8'h7F;
    localparam logic [7:0] SEG_9     = 8'h6F;
    localparam logic [7:0] SEG_BLANK = 8'h00;
    localparam logic [7:0] SEG_DP    = 8'h80;

endpackage

// File: rtl/smg_seg_dec.sv
// Purpose: BCD digit + blank + dp flag to 8-bit active-high segment pattern.
// Latency: combinational.
// Backpressure: none.
module smg_seg_dec
    import smg_pkg::*;
(
    input  logic [3:0] digit,
    input  logic       blank,
    input  logic       dp,
    output logic [7:0] seg
);

    logic [7:0] code;

    always_comb begin
        code = SEG_BLANK;
        case (digit)
            4'd0: code = SEG_0;
            4'd1: code = SEG_1;
            4'd2: code = SEG_2;
            4'd3: code = SEG_3;
            4'd4: code = SEG_4;
            4'd5: code = SEG_5;
            4'd6: code = SEG_6;
            4'd7: code = SEG_7;
            4'd8: code = SEG_8;
            4'd9: code = SEG_9;
            default: code = SEG_BLANK;
        endcase
    end

    assign seg = (blank ? SEG_BLANK : code) | (dp ? SEG_DP : SEG_BLANK);

endmodule

// File: rtl/smg_scan_ctrl.sv
// Purpose: clamp a binary value to 9999, convert to BCD serially, scan 4 digits.
// Latency: 17 cycles transfer-to-commit; display follows at the next scan tick.
// Backpressure: in_ready is high only in IDLE; in_valid is ignored while busy.
module smg_scan_ctrl
    import smg_pkg::*;
#(
    parameter int SCAN_DIV = 50000,
    parameter bit BLANK_LZ = 1'b1
) (
    input  logic        clk,
    input  logic        RST,
    input  logic        in_valid,
    input  logic [15:0] in_data,
    output logic        in_ready,
    output logic        ovf,
    output logic [2:0]  smg_sel,
    output logic [7:0]  smg_duan
);

    localparam int PW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);

    smg_state_t  state;
    logic [15:0] bin_q;
    logic [15:0] bcd_q;
    logic [15:0] bcd_adj;
    logic [3:0]  step_q;
    logic        ovf_pend;
    logic [15:0] disp_q;   // committed digits, thousands in [15:12]

    // Add-3 correction applied before each shift
    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < 4; i++) begin
            if (bcd_q[i*4 +: 4] >= 4'd5)
                bcd_adj[i*4 +: 4] = bcd_q[i*4 +: 4] + 4'd3;
        end
    end

    always_ff @(posedge clk) begin
        if (RST) begin
            state    <= S_IDLE;
            in_ready <= 1'b1;
            ovf      <= 1'b0;
            ovf_pend <= 1'b0;
            bin_q    <= '0;
            bcd_q    <= '0;
            step_q   <= '0;
            disp_q   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        bin_q    <= (in_data > SMG_MAX) ? SMG_MAX : in_data;
                        ovf_pend <= (in_data > SMG_MAX);
                        bcd_q    <= '0;
                        step_q   <= '0;
                        in_ready <= 1'b0;
                        state    <= S_CONV;
                    end
                end
                S_CONV: begin
                    {bcd_q, bin_q} <= {bcd_adj[14:0], bin_q, 1'b0};
                    step_q         <= step_q + 4'd1;
                    if (step_q == 4'd15)
                        state <= S_COMMIT;
                end
                S_COMMIT: begin
                    disp_q   <= bcd_q;
                    ovf      <= ovf_pend;
                    in_ready <= 1'b1;
                    state    <= S_IDLE;
                end
                default: begin
                    in_ready <= 1'b1;
                    state    <= S_IDLE;
                end
            endcase
        end
    end

    logic [PW-1:0] presc_q;
    logic [1:0]    sel_q;
    logic [1:0]    sel_nxt;
    logic          tick;
    logic [3:0]    dig_cur;
    logic          blank_cur;
    logic          z0, z1, z2;
    logic [7:0]    seg_cur;

    assign tick    = (presc_q == PRESC_LAST);
    assign sel_nxt = sel_q + 2'd1;

    // A digit is blanked when it and every higher digit is zero
    assign z0 = BLANK_LZ && (disp_q[15:12] == 4'd0);
    assign z1 = z0 && (disp_q[11:8] == 4'd0);
    assign z2 = z1 && (disp_q[7:4] == 4'd0);

    always_comb begin
        dig_cur   = disp_q[3:0];
        blank_cur = 1'b0;
        case (sel_nxt)
            2'd0: begin dig_cur = disp_q[15:12]; blank_cur = z0; end
            2'd1: begin dig_cur = disp_q[11:8];  blank_cur = z1; end
            2'd2: begin dig_cur = disp_q[7:4];   blank_cur = z2; end
            default: begin dig_cur = disp_q[3:0]; blank_cur = 1'b0; end
        endcase
    end

    smg_seg_dec u_seg_dec (
        .digit (dig_cur),
        .blank (blank_cur),
        .dp    (ovf && (sel_nxt == 2'd3)),
        .seg   (seg_cur)
    );

    always_ff @(posedge clk) begin
        if (RST) begin
            presc_q  <= '0;
            sel_q    <= 2'd0;
            smg_duan <= SEG_BLANK;
        end else if (tick) begin
            presc_q  <= '0;
            sel_q    <= sel_nxt;
            smg_duan <= seg_cur;
        end else begin
            presc_q  <= presc_q + PW'(1);
        end
    end

    assign smg_sel = {1'b0, sel_q};

endmodule

// File: tb/tb_smg_scan_ctrl.sv
// Directed bench for smg_scan_ctrl with SCAN_DIV=4, BLANK_LZ=1.
module tb_smg_scan_ctrl;

    logic        clk = 1'b0;
    logic        RST = 1'b1;
    logic        in_valid = 1'b0;
    logic [15:0] in_data = 16'd0;
    logic        in_ready;
    logic        ovf;
    logic [2:0]  smg_sel;
    logic [7:0]  smg_duan;

    int n_pass = 0;
    int n_fail = 0;

    smg_scan_ctrl #(.SCAN_DIV(4), .BLANK_LZ(1'b1)) dut (
        .clk      (clk),
        .RST      (RST),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .ovf      (ovf),
        .smg_sel  (smg_sel),
        .smg_duan (smg_duan)
    );

    always #5 clk = ~clk;

    // Scan-timing monitor: independent prescaler model of a 4-cycle digit slot
    int         pm = 0;
    logic       tick_seen = 1'b0;
    logic       rst_seen = 1'b1;
    logic       mon_en = 1'b0;
    logic [2:0] prev_sel = 3'd0;
    logic [7:0] prev_duan = 8'd0;

    always @(posedge clk) begin
        tick_seen = (pm == 3);
        rst_seen  = RST;
        if (RST || pm == 3) pm = 0;
        else pm = pm + 1;
    end

    always @(negedge clk) begin
        if (mon_en) begin
            if (smg_sel > 3'd3 ||
                (!rst_seen && !tick_seen && (smg_sel !== prev_sel || smg_duan !== prev_duan))) begin
                n_fail++;
                $display("FAIL scan_timing: sel %0d duan %02h (prev %0d/%02h) tick %0b, required sel<=3 and change only on tick",
                         smg_sel, smg_duan, prev_sel, prev_duan, tick_seen);
            end else n_pass++;
        end
        prev_sel  = smg_sel;
        prev_duan = smg_duan;
    end

    task automatic send(input logic [15:0] v, output int lat);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = v;
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat = 0;
        while (lat < 100) begin
            @(negedge clk);
            if (in_ready) break;
            lat++;
        end
    endtask

    task automatic wait_ready(output int lat);
        lat = 0;
        while (lat < 100) begin
            @(negedge clk);
            if (in_ready) break;
            lat++;
        end
    endtask

    // Let a tick pass, then record one full scan indexed by smg_sel
    task automatic collect(output logic [3:0][7:0] d);
        d = '1;
        repeat (8) @(negedge clk);
        repeat (16) begin
            @(negedge clk);
            d[smg_sel[1:0]] = smg_duan;
        end
    endtask

    task automatic test_reset;
        RST = 1'b1;
        repeat (3) @(negedge clk);
        RST = 1'b0;
        mon_en = 1'b1;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end else n_pass++;
        if (ovf !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b want 0", ovf); end else n_pass++;
        if (smg_sel !== 3'd0) begin n_fail++; $display("FAIL reset_sel: got %0d want 0", smg_sel); end else n_pass++;
        if (smg_duan !== 8'h00) begin n_fail++; $display("FAIL reset_duan: got %02h want 00", smg_duan); end else n_pass++;
    endtask

    task automatic test_value(input string name, input logic [15:0] v,
                              input logic [3:0][7:0] exp, input logic exp_ovf);
        int lat;
        logic [3:0][7:0] d;
        send(v, lat);
        if (lat !== 17) begin n_fail++; $display("FAIL %s_latency: in_ready low %0d cycles want 17", name, lat); end else n_pass++;
        if (ovf !== exp_ovf) begin n_fail++; $display("FAIL %s_ovf: got %b want %b", name, ovf, exp_ovf); end else n_pass++;
        collect(d);
        for (int i = 0; i < 4; i++) begin
            if (d[i] !== exp[i]) begin
                n_fail++;
                $display("FAIL %s_sel%0d: duan %02h want %02h", name, i, d[i], exp[i]);
            end else n_pass++;
        end
    endtask

    task automatic test_ignore_valid;
        int lat;
        logic [3:0][7:0] d;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 16'd1111;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (5) @(negedge clk);
        in_valid = 1'b1;
        in_data  = 16'd5555;
        @(negedge clk);
        in_valid = 1'b0;
        if (in_ready !== 1'b0) begin n_fail++; $display("FAIL ignore_busy: in_ready %b want 0", in_ready); end else n_pass++;
        wait_ready(lat);
        if (lat >= 100) begin n_fail++; $display("FAIL ignore_ready_timeout: waited %0d cycles", lat); end else n_pass++;
        collect(d);
        for (int i = 0; i < 4; i++) begin
            if (d[i] !== 8'h06) begin
                n_fail++;
                $display("FAIL ignore_sel%0d: duan %02h want 06", i, d[i]);
            end else n_pass++;
        end
    endtask

    task automatic test_rst_mid_conv;
        logic [3:0][7:0] d;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 16'd9999;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (8) @(negedge clk);
        RST = 1'b1;
        @(negedge clk);
        RST = 1'b0;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready: got %b want 1", in_ready); end else n_pass++;
        if (ovf !== 1'b0) begin n_fail++; $display("FAIL rst_ovf: got %b want 0", ovf); end else n_pass++;
        if (smg_sel !== 3'd0) begin n_fail++; $display("FAIL rst_sel: got %0d want 0", smg_sel); end else n_pass++;
        if (smg_duan !== 8'h00) begin n_fail++; $display("FAIL rst_duan: got %02h want 00", smg_duan); end else n_pass++;
        collect(d);
        for (int i = 0; i < 4; i++) begin
            if (d[i] !== ((i == 3) ? 8'h3F : 8'h00)) begin
                n_fail++;
                $display("FAIL rst_sel%0d: duan %02h want %02h", i, d[i], (i == 3) ? 8'h3F : 8'h00);
            end else n_pass++;
        end
    endtask

    initial begin
        logic [3:0][7:0] e;
        test_reset();
        e = {8'h66, 8'h4F, 8'h5B, 8'h06};
        test_value("v1234", 16'd1234, e, 1'b0);
        e = {8'h5B, 8'h66, 8'h00, 8'h00};
        test_value("v42", 16'd42, e, 1'b0);
        e = {8'h3F, 8'h00, 8'h00, 8'h00};
        test_value("v0", 16'd0, e, 1'b0);
        e = {8'hEF, 8'h6F, 8'h6F, 8'h6F};
        test_value("v12345", 16'd12345, e, 1'b1);
        e = {8'h07, 8'h00, 8'h00, 8'h00};
        test_value("v7", 16'd7, e, 1'b0);
        test_ignore_valid();
        test_rst_mid_conv();
        $display("%0d/%0d checks passed", n_pass, n_pass + n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
